// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream in and instruction-memory write port out
interface instr_mem_loader_if #(parameter int ADDR_WIDTH = 10);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles LE words from a byte stream, writes them from address 0, holds the core in reset until loaded
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ADDR_WIDTH:0] word_count,
  instr_mem_loader_if.slave bus,
  output logic cpu_reset,
  output logic busy,
  output logic done,
  output logic error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] wc_q, wc_d, wl_q, wl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic cpu_reset_q, cpu_reset_d, in_ready_q, in_ready_d, mem_we_q, mem_we_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic accept;
  assign accept = bus.in_valid & in_ready_q;
  // next state plus every output precomputed from the next state so outputs leave flops
  always_comb begin
    state_d = state_q;
    wc_d = wc_q;
    wl_d = wl_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    idx_d = idx_q;
    tmo_d = tmo_q;
    cpu_reset_d = cpu_reset_q;
    case (state_q)
      IDLE, ERROR: if (start) begin
        cpu_reset_d = 1'b1;
        if (word_count == '0) state_d = DONE;
        else if (word_count > MAX_WORDS) state_d = ERROR;
        else begin
          state_d = LOAD;
          wc_d = word_count;
          wl_d = '0;
          addr_d = '0;
          idx_d = '0;
          tmo_d = '0;
        end
      end
      LOAD: if (accept) begin
        wdata_d[{idx_q, 3'b000} +: 8] = bus.in_data;
        idx_d = idx_q + 2'd1;
        tmo_d = '0;
        state_d = (idx_q == 2'd3) ? WRITE : LOAD;
      end else begin
        tmo_d = tmo_q + TW'(1);
        state_d = (TIMEOUT != 0 && tmo_d == TW'(TIMEOUT)) ? ERROR : LOAD;
      end
      WRITE: begin
        wl_d = wl_q + (ADDR_WIDTH + 1)'(1);
        state_d = (wl_d == wc_q) ? DONE : LOAD;
        addr_d = (wl_d == wc_q) ? addr_q : addr_q + ADDR_WIDTH'(1);
      end
      DONE: begin
        state_d = IDLE;
        cpu_reset_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == LOAD;
    mem_we_d = state_d == WRITE;
    busy_d = state_d == LOAD || state_d == WRITE;
    done_d = state_d == DONE;
    error_d = state_d == ERROR;
  end
  // single state register; reset discards any partial word and holds the core in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wc_q <= '0;
      wl_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
      cpu_reset_q <= 1'b1;
      in_ready_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q <= wc_d;
      wl_q <= wl_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
      cpu_reset_q <= cpu_reset_d;
      in_ready_q <= in_ready_d;
      mem_we_q <= mem_we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign words_loaded = wl_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed loads against a word-level write scoreboard plus literal pins
module tb_instr_mem_loader;
  localparam int AW = 2;
  localparam int TO = 8;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0] data;
  } wr_t;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [AW:0] word_count = '0;
  logic cpu_reset, busy, done, error;
  logic [AW:0] words_loaded;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_wl = -1;
  wr_t exp_q[$];
  instr_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();
  instr_mem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count), .bus(bus),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // complete words of a byte stream land at consecutive addresses from 0
  function automatic void expect_words(input logic [7:0] bs[$]);
    for (int k = 0; k < bs.size() / 4; k++)
      exp_q.push_back('{addr: AW'(k), data: {bs[4*k+3], bs[4*k+2], bs[4*k+1], bs[4*k]}});
  endfunction
  task automatic do_start(input int wc);
    start = 1;
    word_count = (AW + 1)'(wc);
    tick();
    start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int n;
    bus.in_valid = 0;
    repeat (gap) tick();
    bus.in_valid = 1;
    bus.in_data = b;
    n = 0;
    do begin
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 20);
    bus.in_valid = 0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %h not taken within 20 cycles", b);
    end
  endtask
  task automatic send_all(input logic [7:0] bs[$], input int from, input int to);
    for (int i = from; i < to; i++) send_byte(bs[i], 0);
  endtask
  task automatic finish_chk(input string name, input int addr, input logic [31:0] data, input int wl);
    chk({name, "_we"}, 32'(bus.mem_we), 1);
    chk({name, "_addr"}, 32'(bus.mem_addr), addr);
    chk({name, "_data"}, bus.mem_wdata, data);
    tick();
    chk({name, "_done"}, 32'(done), 1);
    chk({name, "_cpurst_held"}, 32'(cpu_reset), 1);
    chk({name, "_wl"}, 32'(words_loaded), wl);
    tick();
    chk({name, "_cpurst_rel"}, 32'(cpu_reset), 0);
    chk({name, "_done_pulse"}, 32'(done), 0);
    chk({name, "_idle"}, 32'(busy), 0);
  endtask
  // scoreboard: every write must match the next expected word; cross-signal rules every cycle
  always @(negedge clk) begin
    wr_t w;
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
        chk("wr_data", bus.mem_wdata, w.data);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_wl >= 0) chk("done_words", 32'(words_loaded), exp_wl);
    end
    chk("ready_with_we", 32'(bus.in_ready & bus.mem_we), 0);
    chk("error_cpu_free", 32'(error & ~cpu_reset), 0);
    chk("ready_not_busy", 32'(bus.in_ready & ~(busy & cpu_reset)), 0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] bs[$];
    bus.in_valid = 0;
    bus.in_data = '0;
    tick();
    tick();
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_wl", 32'(words_loaded), 0);
    reset = 0;
    tick();
    chk("idle_ignores_bytes", 32'(bus.in_ready), 0);
    // nominal two-word load, no gaps
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    expect_words(bs);
    exp_wl = 2;
    do_start(2);
    chk("nom_busy", 32'(busy), 1);
    chk("nom_ready", 32'(bus.in_ready), 1);
    send_all(bs, 0, 4);
    chk("nom_w0_we", 32'(bus.mem_we), 1);
    chk("nom_w0_addr", 32'(bus.mem_addr), 0);
    chk("nom_w0_data", bus.mem_wdata, 32'h00000013);
    chk("nom_w0_ready", 32'(bus.in_ready), 0);
    send_all(bs, 4, 8);
    finish_chk("nom", 1, 32'h00100093, 2);
    // gapped stream; a 7-cycle gap stays just below the timeout
    bs = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    expect_words(bs);
    exp_wl = 1;
    do_start(1);
    send_byte(bs[0], 7);
    chk("gap_no_error", 32'(error), 0);
    for (int i = 1; i < 4; i++) send_byte(bs[i], 3);
    finish_chk("gap", 0, 32'hDEADBEEF, 1);
    // timeout after two bytes
    do_start(1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (TO - 1) tick();
    chk("tmo_not_yet", 32'(error), 0);
    chk("tmo_still_busy", 32'(busy), 1);
    tick();
    chk("tmo_error", 32'(error), 1);
    chk("tmo_cpu_reset", 32'(cpu_reset), 1);
    chk("tmo_ready", 32'(bus.in_ready), 0);
    chk("tmo_busy", 32'(busy), 0);
    tick();
    chk("tmo_sticky", 32'(error), 1);
    bs = '{8'h01, 8'h02, 8'h03, 8'h04};
    expect_words(bs);
    do_start(1);
    chk("recover_clears_error", 32'(error), 0);
    send_all(bs, 0, 4);
    finish_chk("recover", 0, 32'h04030201, 1);
    // bounds at ADDR_WIDTH=2
    do_start(5);
    chk("over_error", 32'(error), 1);
    chk("over_busy", 32'(busy), 0);
    chk("over_ready", 32'(bus.in_ready), 0);
    tick();
    bs.delete();
    for (int i = 0; i < 16; i++) bs.push_back(8'(i * 16 + 3));
    expect_words(bs);
    exp_wl = 4;
    do_start(4);
    chk("full_error_cleared", 32'(error), 0);
    send_all(bs, 0, 16);
    finish_chk("full", 3, 32'hF3E3D3C3, 4);
    exp_wl = -1;
    do_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    tick();
    chk("zero_cpu_released", 32'(cpu_reset), 0);
    chk("zero_done_pulse", 32'(done), 0);
    // reset after six bytes: only the first word is written
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expect_words(bs);
    do_start(2);
    send_all(bs, 0, 6);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 1);
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    chk("mid_rst_we", 32'(bus.mem_we), 0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wl", 32'(words_loaded), 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    tick();
    // start during LOAD must not disturb the running load
    bs = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    expect_words(bs);
    exp_wl = 2;
    do_start(2);
    send_all(bs, 0, 2);
    do_start(1);
    chk("ign_busy", 32'(busy), 1);
    send_all(bs, 2, 8);
    finish_chk("ign", 1, 32'h3C2D1E0F, 2);
    tick();
    chk("all_writes_seen", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side companion to the RISC-V core's instruction memory: accepts a byte stream from the host/bridge, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory write port from address 0. It holds the CPU in reset from power-up and for the whole load, and releases it only after a complete, error-free load. It sits between the bridge/data-slot logic and the instruction memory, alongside the core.

## Interface
Parameters:
- ADDR_WIDTH, 10: instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- TIMEOUT, 65535: maximum idle cycles between accepted bytes during a load; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or ERROR.
- word_count  in  ADDR_WIDTH+1  number of words to load; sampled on an honoured start.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte; the first byte of each word is bits [7:0].
- in_ready  out  1  loader accepts a byte; transfer when in_valid & in_ready.
- mem_we  out  1  single-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  holds the RISC-V core in reset.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  single-cycle pulse on successful completion.
- error  out  1  sticky; high in ERROR.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current/last load.

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- Reset values: state IDLE, cpu_reset 1, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, error 0, words_loaded 0, byte index 0, timeout counter 0.
- IDLE, start=1:
  - word_count = 0: go to DONE.
  - word_count > 2^ADDR_WIDTH: go to ERROR.
  - Otherwise go to LOAD and clear words_loaded, mem_addr, byte index, and the timeout counter.
  - cpu_reset is set to 1 on every honoured start.
- LOAD:
  - in_ready=1. Each accepted byte is shifted into word bits [8*idx+7:8*idx]. The byte index is 2 bits and wraps 3->0.
  - On the 4th accepted byte, go to WRITE.
  - Timeout counter increments on every LOAD cycle without an accepted byte and clears on any accepted byte. When it reaches TIMEOUT (TIMEOUT≠0), go to ERROR.
- WRITE (one cycle):
  - mem_we=1 and in_ready=0; mem_addr and mem_wdata are stable and hold the completed word.
  - words_loaded increments.
  - If the incremented words_loaded equals word_count, go to DONE. Otherwise increment mem_addr and return to LOAD.
- DONE (one cycle): done=1, then cpu_reset←0 and go to IDLE.
- ERROR: error=1, cpu_reset stays 1, in_ready=0. Leave only on start, which follows the IDLE rules above and clears error.
- start outside IDLE/ERROR is ignored.
- mem_addr never exceeds 2^ADDR_WIDTH-1. The word_count check guarantees no wrap.
- Bytes offered in IDLE/DONE/ERROR are not accepted (in_ready=0).

## Timing
- 4th byte of a word accepted at edge N: mem_we=1 in cycle N+1; in_ready returns to 1 in N+2 if more words remain.
- Last word: mem_we in N+1, done in N+2, cpu_reset=0 from N+3.
- Maximum throughput: 4 bytes per 5 cycles.
- Back-to-back bytes are accepted every cycle within a word. Gaps (in_valid low) only advance the timeout counter.
- reset asserted mid-load: at the next edge all outputs return to reset values. The partial word is discarded, no mem_we is issued, and cpu_reset=1.
- start and reset in the same cycle: reset wins.
- Timeout and a byte acceptance in the same cycle: the byte wins and the counter clears.

## Test plan
- Nominal load: word_count=2, bytes 13 00 00 00 93 00 10 00 with no gaps.
  - Required: mem_we at addr 0 with 0x00000013, then addr 1 with 0x00100093.
  - Then one done pulse, cpu_reset 1->0, words_loaded=2.
- Gapped/backpressured stream: in_valid low for 3 random cycles between bytes, TIMEOUT=16, word_count=1, bytes EF BE AD DE.
  - Required: one write of 0xDEADBEEF at addr 0 and done.
- Timeout: word_count=1, TIMEOUT=8, send 2 bytes then idle.
  - Required: error=1 exactly 8 idle cycles later, no mem_we, cpu_reset stays 1.
  - A following start with word_count=1 plus 4 bytes completes normally and clears error.
- Bounds (ADDR_WIDTH=2):
  - word_count=5: ERROR immediately, no write.
  - word_count=4: writes at addr 0..3, then done.
  - word_count=0: done the cycle after start, cpu_reset released, no write.
- Reset mid-load: word_count=2, assert reset after 6 bytes.
  - Required: only addr 0 written, all outputs at reset values next cycle, cpu_reset=1, in_ready=0.
- Ignored start: pulse start while in LOAD with a different word_count.
  - Required: the original load completes with the original count and addresses.
